// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle MIPS fetch stage owning PC, IR and the imem req/ready handshake.
// Define BRANCH_DELAY_SLOT_EN to delay taken branches by one instruction (delay slot).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, br_target, next_pc;
  logic advance;
`ifdef BRANCH_DELAY_SLOT_EN
  logic pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = imem_ready ? EXEC : FETCH;
      EXEC:    state_d = stall ? EXEC : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    imem_req = state_q == FETCH;
    instr_valid = state_q == EXEC;
  end
  assign advance = (state_q == EXEC) & ~stall;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  always_comb begin
    ir_d = (state_q == FETCH && imem_ready) ? imem_rdata : ir_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d = pend_q;
    tgt_d = tgt_q;
    next_pc = pc_plus4;
    if (advance) begin
      if (pend_q) begin
        next_pc = tgt_q;
        pend_d = 1'b0;
      end else if (branch && zero) begin
        pend_d = 1'b1;
        tgt_d = br_target;
      end
    end
`else
    next_pc = (branch && zero) ? br_target : pc_plus4;
`endif
    pc_d = advance ? {next_pc[31:2], 2'b00} : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
      ir_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end
`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      tgt_q <= 32'd0;
    end else begin
      pend_q <= pend_d;
      tgt_q <= tgt_d;
    end
  end
`endif
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign imm = ir_q[15:0];
  assign func = ir_q[5:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + randomized check of instr_fetch_unit against a phase-level model.
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, imem_ready = 1'b0, stall = 1'b0, branch = 1'b0, zero = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  int n_vec = 0, n_err = 0;
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2;
  int m_ph = P_IDLE;
  logic [31:0] m_pc = 32'd0, m_ir = 32'd0, m_tgt = 32'd0;
  logic m_pend = 1'b0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
    .zero(zero), .instr_valid(instr_valid), .op(op), .func(func), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the spec rules, then compare every output.
  task automatic step(input logic r_n, input logic rdy, input logic [31:0] rdata,
                      input logic st, input logic br, input logic z);
    logic [31:0] p4, tgt;
    int s;
    rst_n = r_n; imem_ready = rdy; imem_rdata = rdata; stall = st; branch = br; zero = z;
    if (!r_n) begin
      m_ph = P_IDLE; m_pc = 32'd0; m_ir = 32'd0; m_pend = 1'b0;
    end else if (m_ph == P_IDLE) m_ph = P_FETCH;
    else if (m_ph == P_FETCH) begin
      if (rdy) begin m_ir = rdata; m_ph = P_EXEC; end
    end else if (!st) begin
      s = $signed(m_ir[15:0]);
      p4 = m_pc + 32'd4;
      tgt = p4 + 32'(s * 4);
`ifdef BRANCH_DELAY_SLOT_EN
      if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; end
      else begin
        if (br && z) begin m_tgt = tgt; m_pend = 1'b1; end
        m_pc = p4;
      end
`else
      m_pc = (br && z) ? tgt : p4;
`endif
      m_ph = P_FETCH;
    end
    @(posedge clk); #1;
    chk("imem_req", 32'(imem_req), 32'(m_ph == P_FETCH));
    chk("instr_valid", 32'(instr_valid), 32'(m_ph == P_EXEC));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("op", 32'(op), 32'(m_ir >> 26));
    chk("rs", 32'(rs), 32'((m_ir >> 21) & 32'h1f));
    chk("rt", 32'(rt), 32'((m_ir >> 16) & 32'h1f));
    chk("rd", 32'(rd), 32'((m_ir >> 11) & 32'h1f));
    chk("imm", 32'(imm), m_ir & 32'hffff);
    chk("func", 32'(func), m_ir & 32'h3f);
  endtask

  task automatic run_instr(input logic [31:0] w, input logic br, input logic z);
    step(1'b1, 1'b1, w, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, br, z);
  endtask

  initial begin
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'd0);
    step(1'b1, 1'b1, 32'hdead_beef, 1'b1, 1'b1, 1'b1);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    step(1'b1, 1'b1, 32'h012A_4020, 1'b0, 1'b0, 1'b0);
    chk("t2_op", 32'(op), 32'h0);
    chk("t2_func", 32'(func), 32'h20);
    chk("t2_rs", 32'(rs), 32'd9);
    chk("t2_rt", 32'(rt), 32'd10);
    chk("t2_rd", 32'(rd), 32'd8);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    step(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t2_next", imem_addr, 32'h4);
    run_instr(32'd0, 1'b0, 1'b0);
    run_instr(32'd0, 1'b0, 1'b0);
    run_instr(32'd0, 1'b0, 1'b0);
    chk("t3_pc10", imem_addr, 32'h10);
    run_instr(32'h1000_0003, 1'b1, 1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("t6_slot", imem_addr, 32'h14);
    run_instr(32'h1000_0005, 1'b1, 1'b1);
`endif
    chk("t3_taken", imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h2222_3333, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("t4_stall_valid", 32'(instr_valid), 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_op", 32'(op), 32'd0);
    chk("t5_pc", pc, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_FFFE, 1'b1, 1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
    run_instr(32'd0, 1'b0, 1'b0);
`endif
    chk("t4_top", pc, 32'hFFFF_FFFC);
    run_instr(32'd0, 1'b0, 1'b0);
    chk("t4_wrap", pc, 32'h0);
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6), $urandom,
           ($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
